read_line_buffer: RTL and testbench

- Parametrised successor to the CPU's 4-word read buffer: collects a burst of read beats from the memory bus into a DEPTH-word line register.
- Adds critical-word-first fill: the burst starts at any word offset and wraps modulo DEPTH.
- Adds per-word valid flags so the CPU can consume the critical word before the line completes, an explicit IDLE/FILL/DONE state machine, and sticky overflow detection.
- Sits between the bus read-data return path and the CPU fetch/load logic.

---
 rtl/read_line_buffer_pkg.sv | 22 ++
 rtl/read_line_buffer.sv | 106 ++++++++++
 tb/tb_read_line_buffer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_line_buffer_pkg.sv
// Shared types and index helper for the read line buffer.
// Word indices are carried at a fixed maximum width and narrowed by the user.
package read_line_buffer_pkg;

    localparam int MAX_IDX_W = 16;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_FILL = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_t;

    // The caller passes DEPTH-1 as the mask, so DEPTH must be a power of two.
    function automatic logic [MAX_IDX_W-1:0] wrap_idx(
        input logic [MAX_IDX_W-1:0] base,
        input logic [MAX_IDX_W-1:0] cnt,
        input logic [MAX_IDX_W-1:0] mask
    );
        return (base + cnt) & mask;
    endfunction

endpackage

// File: rtl/read_line_buffer.sv
// Collects a critical-word-first read burst into a DEPTH-word line and
// exposes per-word valid flags, fill progress and sticky overflow.
//
// state     | meaning
// FILL_IDLE | no fill in progress, beats are dropped and flagged
// FILL_FILL | accepting beats at (base + count) mod DEPTH
// FILL_DONE | all DEPTH words valid, line held stable
module read_line_buffer
    import read_line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             start,
    input  logic [IDX_W-1:0]                 start_offset,
    input  logic [DATA_WIDTH-1:0]            read_data,
    input  logic                             read_data_valid,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0] data,
    output logic [DEPTH-1:0]                 word_valid,
    output logic [CNT_W-1:0]                 count,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow
);

    fill_state_t                     state_q, state_d;
    logic [IDX_W-1:0]                base_q, base_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic                            ovf_q, ovf_d;
    logic [IDX_W-1:0]                wr_idx;

    assign wr_idx = IDX_W'(wrap_idx(MAX_IDX_W'(base_q), MAX_IDX_W'(count_q),
                                    MAX_IDX_W'(DEPTH - 1)));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        if (start) begin
            state_d = FILL_FILL;
            base_d  = start_offset;
            count_d = '0;
            valid_d = '0;
            ovf_d   = 1'b0;
            // A beat alongside start is the critical word of the new line.
            if (read_data_valid) begin
                data_d[start_offset]  = read_data;
                valid_d[start_offset] = 1'b1;
                count_d               = CNT_W'(1);
            end
        end else if (clear) begin
            state_d = FILL_IDLE;
            count_d = '0;
            valid_d = '0;
            ovf_d   = 1'b0;
        end else if (read_data_valid) begin
            if (state_q == FILL_FILL) begin
                data_d[wr_idx]  = read_data;
                valid_d[wr_idx] = 1'b1;
                count_d         = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DEPTH - 1)) begin
                    state_d = FILL_DONE;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL_IDLE;
            base_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data       = data_q;
    assign word_valid = valid_q;
    assign count      = count_q;
    assign busy       = (state_q == FILL_FILL);
    assign done       = (state_q == FILL_DONE);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_read_line_buffer.sv
// Directed bench for read_line_buffer: a default 4x32 instance and an 8x64
// instance, each scenario in its own task with hand-computed expectations.
module tb_read_line_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 4 x 32 instance
    logic              reset_n, clear, start, rdv;
    logic [1:0]        off;
    logic [31:0]       rd;
    logic [3:0][31:0]  data4;
    logic [3:0]        wv4;
    logic [2:0]        cnt4;
    logic              busy4, done4, ovf4;

    // 8 x 64 instance
    logic              reset8_n, clear8, start8, rdv8;
    logic [2:0]        off8;
    logic [63:0]       rd8;
    logic [7:0][63:0]  data8;
    logic [7:0]        wv8;
    logic [3:0]        cnt8;
    logic              busy8, done8, ovf8;

    read_line_buffer u_dut4 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start(start),
        .start_offset(off), .read_data(rd), .read_data_valid(rdv),
        .data(data4), .word_valid(wv4), .count(cnt4),
        .busy(busy4), .done(done4), .overflow(ovf4)
    );

    read_line_buffer #(.DATA_WIDTH(64), .DEPTH(8)) u_dut8 (
        .clk(clk), .reset_n(reset8_n), .clear(clear8), .start(start8),
        .start_offset(off8), .read_data(rd8), .read_data_valid(rdv8),
        .data(data8), .word_valid(wv8), .count(cnt8),
        .busy(busy8), .done(done8), .overflow(ovf8)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        start = 1'b0; clear = 1'b0; rdv = 1'b0; rd = '0; off = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; reset8_n = 1'b0;
        idle4();
        clear8 = 1'b0; start8 = 1'b0; rdv8 = 1'b0; rd8 = '0; off8 = '0;
        cyc(); cyc();
        checks++;
        if ({data4, wv4, cnt4, busy4, done4, ovf4} !== '0) begin
            errors++;
            $display("FAIL reset4: got data=%h wv=%b cnt=%0d b/d/o=%b%b%b, want all zero",
                     data4, wv4, cnt4, busy4, done4, ovf4);
        end
        checks++;
        if ({data8, wv8, cnt8, busy8, done8, ovf8} !== '0) begin
            errors++;
            $display("FAIL reset8: got wv=%b cnt=%0d, want all zero", wv8, cnt8);
        end
        @(negedge clk);
        reset_n = 1'b1; reset8_n = 1'b1;
        cyc();
    endtask

    task automatic test_offset0();
        logic [3:0] exp_wv [4];
        exp_wv = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        start = 1'b1; off = 2'd0;
        cyc();
        start = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || cnt4 !== 3'd0 || wv4 !== 4'b0000) begin
            errors++;
            $display("FAIL off0_start: got busy=%b cnt=%0d wv=%b, want 1 0 0000", busy4, cnt4, wv4);
        end
        for (int i = 0; i < 4; i++) begin
            rdv = 1'b1; rd = 32'hA0 + 32'(i);
            cyc();
            checks++;
            if (wv4 !== exp_wv[i] || cnt4 !== 3'(i + 1)) begin
                errors++;
                $display("FAIL off0_beat%0d: got wv=%b cnt=%0d, want wv=%b cnt=%0d",
                         i, wv4, cnt4, exp_wv[i], i + 1);
            end
        end
        rdv = 1'b0;
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 ||
            data4 !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
            errors++;
            $display("FAIL off0_done: got done=%b busy=%b data=%h, want 1 0 a3a2a1a0 line",
                     done4, busy4, data4);
        end
    endtask

    task automatic test_wrap_offset2();
        logic [3:0] exp_wv [4];
        exp_wv = '{4'b0100, 4'b1100, 4'b1101, 4'b1111};
        start = 1'b1; off = 2'd2;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdv = 1'b1; rd = 32'hB0 + 32'(i);
            cyc();
            checks++;
            if (wv4 !== exp_wv[i] || done4 !== (i == 3)) begin
                errors++;
                $display("FAIL wrap_beat%0d: got wv=%b done=%b, want wv=%b done=%b",
                         i, wv4, done4, exp_wv[i], i == 3);
            end
        end
        rdv = 1'b0;
        checks++;
        if (data4 !== {32'hB1, 32'hB0, 32'hB3, 32'hB2}) begin
            errors++;
            $display("FAIL wrap_data: got %h, want b1 b0 b3 b2 (word3..0)", data4);
        end
    endtask

    task automatic test_same_cycle_start();
        start = 1'b1; off = 2'd1; rdv = 1'b1; rd = 32'hC0;
        cyc();
        start = 1'b0; rdv = 1'b0;
        checks++;
        if (data4[1] !== 32'hC0 || cnt4 !== 3'd1 || wv4 !== 4'b0010 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle: got d1=%h cnt=%0d wv=%b busy=%b, want c0 1 0010 1",
                     data4[1], cnt4, wv4, busy4);
        end
    endtask

    task automatic test_overflow_done();
        for (int i = 1; i < 4; i++) begin
            rdv = 1'b1; rd = 32'hC0 + 32'(i);
            cyc();
        end
        rd = 32'hDEAD;
        cyc();
        rdv = 1'b0;
        checks++;
        if (data4 !== {32'hC2, 32'hC1, 32'hC0, 32'hC3} || cnt4 !== 3'd4 ||
            ovf4 !== 1'b1 || done4 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: got data=%h cnt=%0d ovf=%b done=%b, want c2c1c0c3 4 1 1",
                     data4, cnt4, ovf4, done4);
        end
        start = 1'b1; off = 2'd0;
        cyc();
        start = 1'b0;
        checks++;
        if (ovf4 !== 1'b0 || cnt4 !== 3'd0 || wv4 !== 4'b0000 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_restart: got ovf=%b cnt=%0d wv=%b busy=%b, want 0 0 0000 1",
                     ovf4, cnt4, wv4, busy4);
        end
    endtask

    task automatic test_clear_mid_fill();
        rdv = 1'b1; rd = 32'hE0; cyc();
        rd = 32'hE1; cyc();
        clear = 1'b1; rd = 32'hE2;
        cyc();
        clear = 1'b0; rdv = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || cnt4 !== 3'd0 || wv4 !== 4'b0000 ||
            ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got busy=%b done=%b cnt=%0d wv=%b ovf=%b, want idle zeros",
                     busy4, done4, cnt4, wv4, ovf4);
        end
        checks++;
        if (data4 !== {32'hC2, 32'hC1, 32'hE1, 32'hE0}) begin
            errors++;
            $display("FAIL clear_data: got %h, want c2 c1 e1 e0 (word3..0)", data4);
        end
        rdv = 1'b1; rd = 32'h55;
        cyc();
        rdv = 1'b0;
        checks++;
        if (ovf4 !== 1'b1 || cnt4 !== 3'd0 || data4[2] !== 32'hC1 || wv4 !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ovf: got ovf=%b cnt=%0d d2=%h wv=%b, want 1 0 c1 0000",
                     ovf4, cnt4, data4[2], wv4);
        end
    endtask

    task automatic test_clear_start_same_cycle();
        clear = 1'b1; start = 1'b1; off = 2'd3; rdv = 1'b1; rd = 32'hF0;
        cyc();
        idle4();
        checks++;
        if (busy4 !== 1'b1 || cnt4 !== 3'd1 || wv4 !== 4'b1000 || data4[3] !== 32'hF0 ||
            ovf4 !== 1'b0) begin
            errors++;
            $display("FAIL start_wins: got busy=%b cnt=%0d wv=%b d3=%h ovf=%b, want 1 1 1000 f0 0",
                     busy4, cnt4, wv4, data4[3], ovf4);
        end
    endtask

    task automatic test_depth8();
        logic [7:0] exp_wv [8];
        exp_wv = '{8'h80, 8'h81, 8'h83, 8'h87, 8'h8F, 8'h9F, 8'hBF, 8'hFF};
        start8 = 1'b1; off8 = 3'd7;
        cyc();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rdv8 = 1'b1; rd8 = 64'h1234_0000_0000_00D0 + 64'(i);
            cyc();
            checks++;
            if (wv8 !== exp_wv[i] || cnt8 !== 4'(i + 1) || done8 !== (i == 7)) begin
                errors++;
                $display("FAIL d8_beat%0d: got wv=%b cnt=%0d done=%b, want wv=%b cnt=%0d done=%b",
                         i, wv8, cnt8, done8, exp_wv[i], i + 1, i == 7);
            end
        end
        rdv8 = 1'b0;
        checks++;
        if (data8[7] !== 64'h1234_0000_0000_00D0 || data8[0] !== 64'h1234_0000_0000_00D1 ||
            data8[6] !== 64'h1234_0000_0000_00D7 || data8[3] !== 64'h1234_0000_0000_00D4) begin
            errors++;
            $display("FAIL d8_data: got d7=%h d0=%h d6=%h d3=%h, want ..d0 ..d1 ..d7 ..d4",
                     data8[7], data8[0], data8[6], data8[3]);
        end
        start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdv8 = 1'b1; rd8 = 64'hEE + 64'(i);
            cyc();
        end
        #1;
        reset8_n = 1'b0;
        #1;
        checks++;
        if ({data8, wv8, cnt8, busy8, done8, ovf8} !== '0) begin
            errors++;
            $display("FAIL d8_async_reset: got wv=%b cnt=%0d busy=%b d7=%h, want all zero",
                     wv8, cnt8, busy8, data8[7]);
        end
        rdv8 = 1'b0;
        @(negedge clk);
        reset8_n = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_offset0();
        test_wrap_offset2();
        test_same_cycle_start();
        test_overflow_done();
        test_clear_mid_fill();
        test_clear_start_same_cycle();
        test_depth8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
